// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C burst master: bit-level command codes
// exchanged with the bit controller and the byte/burst FSM state encoding.
package i2c_master_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_STOP
    } state_e;

endpackage

// File: rtl/i2c_shift_reg.sv
// DW-wide data shift register: parallel load for write words, MSB-first
// shift with serial input for read words.
module i2c_shift_reg #(
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          shift,
    input  logic          sin,
    output logic [DW-1:0] q
);

    // Load has priority; shifting moves the next bit into the MSB position.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)     q <= '0;
        else if (load)  q <= load_data;
        else if (shift) q <= {q[DW-2:0], sin};
    end

endmodule

// File: rtl/i2c_master_burst_ctrl.sv
// I2C burst master byte/word controller. Sequences START, multi-word WRITE
// or READ bursts with per-word ACK, and optional STOP on top of an external
// bit controller. Aborts on arbitration loss.
// Optional feature macro: I2C_BURST_AUTO_NACK_EN -- when defined, the last
// word of a read burst is always answered with NACK.
module i2c_master_burst_ctrl
    import i2c_master_pkg::*;
#(
    parameter int DW = 8,
    parameter int LW = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Start,
    input  logic          Stop,
    input  logic          Read,
    input  logic          Write,
    input  logic [LW-1:0] Burst_len,
    input  logic          Tx_ack,
    input  logic [DW-1:0] Tx_data,
    output logic          Tx_req,
    output logic [DW-1:0] Rx_data,
    output logic          Rx_valid,
    output logic          Rx_ack,
    output logic          Busy,
    output logic          I2C_done,
    input  logic          I2C_al,
    output logic          Al_err,
    output logic [3:0]    Bit_cmd,
    output logic          Bit_txd,
    input  logic          Bit_ack,
    input  logic          Bit_rxd
);

    localparam int            BW       = $clog2(DW);
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

    state_e        state;
    logic [BW-1:0] bit_cnt;
    logic [LW-1:0] word_cnt;
    logic          rd_dir;
    logic          ack_txd;
    logic [DW-1:0] sr_q;
    logic          acc, bit_done, more_words, ack_lvl;
    logic          first_write, next_write, sr_load, sr_shift;

    // Command accept is blocked in the done cycle so held command bits are
    // not taken twice.
    assign acc        = (state == ST_IDLE) && (Start || Stop || Read || Write) && !I2C_done;
    assign bit_done   = Bit_ack && (state != ST_IDLE) && !I2C_al;
    assign more_words = (word_cnt != LW'(1));

`ifdef I2C_BURST_AUTO_NACK_EN
    assign ack_lvl = Tx_ack | ~more_words;
`else
    assign ack_lvl = Tx_ack;
`endif

    // A new write word is captured whenever the FSM enters WRITE.
    assign first_write = (acc && !Start && !Read && Write) ||
                         ((state == ST_START) && bit_done && !Read && Write);
    assign next_write  = (state == ST_ACK) && bit_done && !rd_dir && !Bit_rxd && more_words;
    assign sr_load     = first_write || next_write;
    assign sr_shift    = bit_done && ((state == ST_WRITE) || (state == ST_READ));

    assign Busy    = (state != ST_IDLE);
    assign Bit_txd = (state == ST_WRITE) ? sr_q[DW-1] : ack_txd;

    i2c_shift_reg #(.DW(DW)) u_sr (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .load      (sr_load),
        .load_data (Tx_data),
        .shift     (sr_shift),
        .sin       (Bit_rxd),
        .q         (sr_q)
    );

    // Burst FSM with registered bit commands, counters and status pulses.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            Bit_cmd  <= CMD_NOP;
            ack_txd  <= 1'b0;
            Rx_data  <= '0;
            Rx_valid <= 1'b0;
            Rx_ack   <= 1'b0;
            Tx_req   <= 1'b0;
            I2C_done <= 1'b0;
            Al_err   <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            rd_dir   <= 1'b0;
        end else begin
            Tx_req   <= sr_load;
            Rx_valid <= 1'b0;
            I2C_done <= 1'b0;
            if ((state != ST_IDLE) && I2C_al) begin
                state    <= ST_IDLE;
                Bit_cmd  <= CMD_NOP;
                Al_err   <= 1'b1;
                I2C_done <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: if (acc) begin
                        Al_err   <= 1'b0;
                        word_cnt <= (Burst_len == '0) ? LW'(1) : Burst_len;
                        bit_cnt  <= BIT_LAST;
                        rd_dir   <= Read;
                        if (Start)      begin state <= ST_START; Bit_cmd <= CMD_START; end
                        else if (Read)  begin state <= ST_READ;  Bit_cmd <= CMD_READ;  end
                        else if (Write) begin state <= ST_WRITE; Bit_cmd <= CMD_WRITE; end
                        else            begin state <= ST_STOP;  Bit_cmd <= CMD_STOP;  end
                    end
                    ST_START: if (Bit_ack) begin
                        if (Read)       begin state <= ST_READ;  Bit_cmd <= CMD_READ;  end
                        else if (Write) begin state <= ST_WRITE; Bit_cmd <= CMD_WRITE; end
                        else if (Stop)  begin state <= ST_STOP;  Bit_cmd <= CMD_STOP;  end
                        else begin
                            state    <= ST_IDLE;
                            Bit_cmd  <= CMD_NOP;
                            I2C_done <= 1'b1;
                        end
                    end
                    ST_WRITE, ST_READ: if (Bit_ack) begin
                        if (bit_cnt == '0) begin
                            state <= ST_ACK;
                            if (rd_dir) begin
                                Rx_data  <= {sr_q[DW-2:0], Bit_rxd};
                                Rx_valid <= 1'b1;
                                Bit_cmd  <= CMD_WRITE;
                                ack_txd  <= ack_lvl;
                            end else begin
                                Bit_cmd  <= CMD_READ;
                                ack_txd  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    ST_ACK: if (Bit_ack) begin
                        word_cnt <= word_cnt - 1'b1;
                        if (!rd_dir) Rx_ack <= Bit_rxd;
                        if ((!rd_dir && Bit_rxd) || !more_words) begin
                            if (Stop) begin
                                state   <= ST_STOP;
                                Bit_cmd <= CMD_STOP;
                            end else begin
                                state    <= ST_IDLE;
                                Bit_cmd  <= CMD_NOP;
                                I2C_done <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= BIT_LAST;
                            state   <= rd_dir ? ST_READ : ST_WRITE;
                            Bit_cmd <= rd_dir ? CMD_READ : CMD_WRITE;
                        end
                    end
                    ST_STOP: if (Bit_ack) begin
                        state    <= ST_IDLE;
                        Bit_cmd  <= CMD_NOP;
                        I2C_done <= 1'b1;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        Bit_cmd <= CMD_NOP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_burst_ctrl.sv
// Self-checking bench for i2c_master_burst_ctrl. A behavioural model turns
// each command into the expected list of bit operations and received words;
// a bit-controller/monitor step compares the DUT against it every cycle.
module tb_i2c_master_burst_ctrl;

    localparam int DW = 12;
    localparam int LW = 4;
    localparam logic [3:0] C_NOP   = 4'b0000;
    localparam logic [3:0] C_START = 4'b0001;
    localparam logic [3:0] C_STOP  = 4'b0010;
    localparam logic [3:0] C_WRITE = 4'b0100;
    localparam logic [3:0] C_READ  = 4'b1000;

    logic          Clk = 1'b0, Rst_n = 1'b0;
    logic          Start = 1'b0, Stop = 1'b0, Read = 1'b0, Write = 1'b0;
    logic [LW-1:0] Burst_len = '0;
    logic          Tx_ack = 1'b0;
    logic [DW-1:0] Tx_data = '0;
    logic          Tx_req, Rx_valid, Rx_ack, Busy, I2C_done, Al_err, Bit_txd;
    logic [DW-1:0] Rx_data;
    logic          I2C_al = 1'b0, Bit_ack = 1'b0, Bit_rxd = 1'b0;
    logic [3:0]    Bit_cmd;

    always #5 Clk = ~Clk;

    i2c_master_burst_ctrl #(.DW(DW), .LW(LW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Stop(Stop), .Read(Read), .Write(Write),
        .Burst_len(Burst_len), .Tx_ack(Tx_ack), .Tx_data(Tx_data), .Tx_req(Tx_req),
        .Rx_data(Rx_data), .Rx_valid(Rx_valid), .Rx_ack(Rx_ack), .Busy(Busy),
        .I2C_done(I2C_done), .I2C_al(I2C_al), .Al_err(Al_err), .Bit_cmd(Bit_cmd),
        .Bit_txd(Bit_txd), .Bit_ack(Bit_ack), .Bit_rxd(Bit_rxd)
    );

    typedef struct {
        logic [3:0] cmd;
        bit         chk_txd;
        logic       txd;
        logic       rxd;
    } bit_op_t;

    bit_op_t       exp_q[$];
    logic [DW-1:0] exp_rx_q[$];
    logic [DW-1:0] tx_words[$];
    logic [DW-1:0] got_rx[$];
    logic [DW-1:0] fix_w[$];
    int            tests = 0, fails = 0;
    int            n_txreq = 0, n_done = 0, n_bitops = 0, bc_wait = 0;
    int            exp_tx, last_ops, last_treq;
    logic          exp_rx_ack = 1'b0;
    logic [3:0]    last_cmd = 4'b0;
    logic          last_wr_txd = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_bit_cmd"}, Bit_cmd, C_NOP);
        chk({pfx, "_bit_txd"}, Bit_txd, 0);
        chk({pfx, "_rx_data"}, Rx_data, 0);
        chk({pfx, "_rx_ack"}, Rx_ack, 0);
        chk({pfx, "_al_err"}, Al_err, 0);
        chk({pfx, "_pulses"}, {Tx_req, Rx_valid, I2C_done}, 0);
        chk({pfx, "_busy"}, Busy, 0);
    endtask

    task automatic push(input logic [3:0] c, input bit ct, input logic t, input logic rx);
        bit_op_t o;
        o.cmd = c; o.chk_txd = ct; o.txd = t; o.rxd = rx;
        exp_q.push_back(o);
    endtask

    function automatic logic [DW-1:0] pick_word(input int i);
        if (fix_w.size() > i) return fix_w[i];
        return DW'($urandom);
    endfunction

    // One cycle: sample outputs on the falling edge, act as host and bit controller.
    task automatic step();
        bit_op_t op;
        @(negedge Clk);
        if (Rst_n) begin
            if (Tx_req) begin
                n_txreq++;
                if (tx_words.size() > 0) Tx_data = tx_words.pop_front();
            end
            if (Rx_valid) begin
                got_rx.push_back(Rx_data);
                if (exp_rx_q.size() == 0) chk("rx_valid_unexpected", Rx_valid, 0);
                else chk("rx_data", Rx_data, exp_rx_q.pop_front());
            end
            if (I2C_done) n_done++;
            if (Bit_ack) begin
                Bit_ack = 1'b0;
                bc_wait = $urandom_range(0, 3);
            end else if (Bit_cmd != C_NOP) begin
                if (bc_wait > 0) bc_wait--;
                else begin
                    n_bitops++;
                    last_cmd = Bit_cmd;
                    if (Bit_cmd == C_WRITE) last_wr_txd = Bit_txd;
                    if (exp_q.size() == 0) chk("bit_cmd_unexpected", Bit_cmd, C_NOP);
                    else begin
                        op = exp_q.pop_front();
                        chk("bit_cmd", Bit_cmd, op.cmd);
                        if (op.chk_txd) chk("bit_txd", Bit_txd, op.txd);
                        Bit_rxd = op.rxd;
                    end
                    Bit_ack = 1'b1;
                end
            end
        end
    endtask

    // Expected bit-level transaction for one command.
    task automatic build_model(input bit s, p, r, w, input int blen, input int nack_at, input bit txa);
        int n;
        logic [DW-1:0] wd;
        logic ab;
        n = (blen == 0) ? 1 : blen;
        exp_q.delete(); exp_rx_q.delete(); tx_words.delete(); got_rx.delete();
        exp_tx = 0;
        if (s) push(C_START, 0, 0, 0);
        if (r) begin
            for (int i = 0; i < n; i++) begin
                wd = pick_word(i);
                exp_rx_q.push_back(wd);
                for (int b = DW - 1; b >= 0; b--) push(C_READ, 0, 0, wd[b]);
                ab = txa;
`ifdef I2C_BURST_AUTO_NACK_EN
                if (i == n - 1) ab = 1'b1;
`endif
                push(C_WRITE, 1, ab, 0);
            end
        end else if (w) begin
            for (int i = 0; i < n; i++) begin
                wd = pick_word(i);
                if (i == 0) Tx_data = wd;
                else tx_words.push_back(wd);
                exp_tx++;
                for (int b = DW - 1; b >= 0; b--) push(C_WRITE, 1, wd[b], 0);
                push(C_READ, 0, 0, (i == nack_at));
                exp_rx_ack = (i == nack_at);
                if (i == nack_at) break;
            end
        end
        if (p) push(C_STOP, 0, 0, 0);
    endtask

    task automatic run_cmd(input bit s, p, r, w, input int blen, input int nack_at, input bit txa);
        int cyc, d0, t0, b0;
        build_model(s, p, r, w, blen, nack_at, txa);
        d0 = n_done; t0 = n_txreq; b0 = n_bitops;
        Burst_len = LW'(blen); Tx_ack = txa;
        Start = s; Stop = p; Read = r; Write = w;
        step();
        chk("busy_on_accept", Busy, 1);
        chk("al_err_cleared", Al_err, 0);
        cyc = 0;
        while (n_done == d0 && cyc < 4000) begin step(); cyc++; end
        Start = 0; Stop = 0; Read = 0; Write = 0;
        chk("done_count", n_done - d0, 1);
        chk("bit_ops_left", exp_q.size(), 0);
        chk("rx_words_left", exp_rx_q.size(), 0);
        chk("tx_req_count", n_txreq - t0, exp_tx);
        chk("rx_ack", Rx_ack, exp_rx_ack);
        last_ops = n_bitops - b0;
        last_treq = n_txreq - t0;
        step();
        chk("idle_busy", Busy, 0);
        chk("idle_bit_cmd", Bit_cmd, C_NOP);
    endtask

    initial begin
        int d0, t0, b0, cyc, bl;
        bit s, p, r, w;
        repeat (3) step();
        chk_reset("reset");
        Rst_n = 1'b1;
        step();

        // Write burst of 3 words: 3 x (12 data + 1 ack) bit operations.
        fix_w = '{12'h0A5, 12'h03C, 12'h0FF};
        run_cmd(0, 0, 0, 1, 3, -1, 0);
        chk("wr3_bit_ops", last_ops, 39);
        chk("wr3_tx_req", last_treq, 3);

        // Start + read of 2 words.
        fix_w = '{12'h081, 12'h07E};
        run_cmd(1, 0, 1, 0, 2, -1, 0);
        chk("rd2_count", got_rx.size(), 2);
        chk("rd2_word0", got_rx[0], 12'h081);
        chk("rd2_word1", got_rx[1], 12'h07E);
        chk("rd2_bit_ops", last_ops, 27);
`ifdef I2C_BURST_AUTO_NACK_EN
        chk("rd2_last_ack", last_wr_txd, 1);
`else
        chk("rd2_last_ack", last_wr_txd, 0);
`endif
        fix_w.delete();

        // Write burst of 4 with NACK on word 2, Stop requested.
        run_cmd(0, 1, 0, 1, 4, 1, 0);
        chk("nack_rx_ack", Rx_ack, 1);
        chk("nack_tx_req", last_treq, 2);
        chk("nack_last_cmd", last_cmd, C_STOP);
        chk("nack_bit_ops", last_ops, 27);

        // Burst_len 0 acts as a single word.
        run_cmd(0, 0, 0, 1, 0, -1, 0);
        chk("len0_bit_ops", last_ops, 13);
        chk("len0_tx_req", last_treq, 1);

        // Arbitration loss in the middle of word 1 of 3.
        build_model(1, 0, 0, 1, 3, -1, 0);
        d0 = n_done; t0 = n_txreq; b0 = n_bitops;
        Burst_len = 4'd3; Start = 1; Write = 1;
        cyc = 0;
        while (n_bitops < b0 + 5 && cyc < 500) begin step(); cyc++; end
        I2C_al = 1'b1;
        step();
        I2C_al = 1'b0;
        chk("al_busy", Busy, 0);
        chk("al_bit_cmd", Bit_cmd, C_NOP);
        chk("al_err_set", Al_err, 1);
        chk("al_done_pulse", I2C_done, 1);
        Start = 0; Write = 0;
        step(); step();
        chk("al_err_sticky", Al_err, 1);
        chk("al_done_count", n_done - d0, 1);
        chk("al_tx_req", n_txreq - t0, 1);
        exp_q.delete(); tx_words.delete();
        run_cmd(0, 0, 1, 0, 1, -1, 1);

        // Reset in the middle of a word drops the transfer silently.
        build_model(0, 1, 0, 1, 2, -1, 0);
        d0 = n_done;
        b0 = n_bitops;
        Burst_len = 4'd2; Write = 1; Stop = 1;
        cyc = 0;
        while (n_bitops < b0 + 4 && cyc < 500) begin step(); cyc++; end
        Rst_n = 1'b0;
        #1;
        chk_reset("mid_reset");
        Write = 0; Stop = 0; Bit_ack = 1'b0; bc_wait = 0;
        exp_q.delete(); tx_words.delete(); exp_rx_ack = 1'b0;
        repeat (3) step();
        Rst_n = 1'b1;
        repeat (3) step();
        chk("reset_no_done", n_done - d0, 0);
        chk_reset("post_reset");

        // Randomized command mix.
        for (int k = 0; k < 25; k++) begin
            s = 1'($urandom); p = 1'($urandom); r = 1'($urandom); w = 1'($urandom);
            if (!(s || p || r || w)) w = 1;
            bl = $urandom_range(0, 15);
            run_cmd(s, p, r, w, bl, $urandom_range(0, 30), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_master_burst_ctrl.md
I2C_MASTER_BURST_CTRL -- requirements
Module: i2c_master_burst_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8: bits per data word (4..16).
REQ-002 SHALL have parameter LW, default 4: width of burst-length field; max burst 2^LW-1 words.
REQ-003 Clk  input  1  system clock; all state on rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Start / Stop / Read / Write  input  1 each  command bits; held until I2C_done.
REQ-006 Burst_len  input  LW  words in burst, sampled on command accept; 0 treated as 1.
REQ-007 Tx_ack  input  1  ACK level master sends after each read word (0=ACK, 1=NACK).
REQ-008 Tx_data  input  DW  next word to write; valid when Tx_req pulses.
REQ-009 Tx_req  output  1  one-cycle pulse: Tx_data captured, present next word.
REQ-010 Rx_data  output  DW  last received word; Rx_valid  output  1  one-cycle pulse with it.
REQ-011 Rx_ack  output  1  slave ACK bit of last written word (1 = NACK received).
REQ-012 Busy  output  1  high whenever state != IDLE.
REQ-013 I2C_done  output  1  one-cycle pulse: whole command (burst plus optional stop) finished or aborted.
REQ-014 I2C_al  input  1  arbitration lost from bit controller; Al_err  output  1  sticky abort flag, cleared on next accepted command.
REQ-015 Bit_cmd  output  4  NOP=0000, START=0001, STOP=0010, WRITE=0100, READ=1000.
REQ-016 Bit_txd  output  1  bit to transmit; Bit_ack  input  1  bit-command-done pulse; Bit_rxd  input  1  received bit.

Function
REQ-017 States: IDLE, START, WRITE, READ, ACK, STOP; priority in IDLE: Start > Read > Write > Stop.
REQ-018 IDLE with any command bit -> load word counter with max(Burst_len,1), registered Bit_cmd valid next cycle.
REQ-019 START: on Bit_ack go READ if Read, else WRITE if Write, else STOP if Stop, else IDLE with I2C_done.
REQ-020 WRITE: internal DW-bit shift register, MSB first; loaded from Tx_data with Tx_req pulse on entry; one Bit_cmd WRITE per bit; after DW Bit_acks -> ACK.
REQ-021 READ: Bit_rxd shifted in on each Bit_ack, MSB first; after DW bits Rx_data updated, Rx_valid pulsed same cycle, -> ACK.
REQ-022 ACK after write: Bit_cmd READ, Rx_ack <= Bit_rxd on Bit_ack; after read: Bit_cmd WRITE, Bit_txd = Tx_ack.
REQ-023 ACK on Bit_ack: word counter decrements; if nonzero -> WRITE/READ (same direction) and next word; if zero -> STOP if Stop, else IDLE with I2C_done.
REQ-024 Write burst SHALL stop early on NACK (Bit_rxd=1): -> STOP if Stop else IDLE, I2C_done pulsed.
REQ-025 STOP: on Bit_ack -> IDLE, Bit_cmd NOP, I2C_done pulsed.
REQ-026 I2C_al high in any state except IDLE: next cycle -> IDLE, Bit_cmd NOP, Al_err=1, I2C_done pulsed; remaining words discarded.
REQ-027 Bit_ack ignored in IDLE; command bits ignored while Busy.
REQ-028 Bit counter log2(DW) bits wide, wraps never: reloaded to DW-1 at each word start.

Reset
REQ-029 Rst_n low: state IDLE, Bit_cmd NOP, Bit_txd 0, Rx_data 0, Rx_ack 0, Al_err 0, all pulses 0, counters 0; mid-burst reset drops transfer without I2C_done.

Configuration
REQ-030 I2C_BURST_AUTO_NACK_EN defined: last read word of a burst SHALL send NACK (Bit_txd=1) regardless of Tx_ack; undefined: Tx_ack used for every word.

Structure
REQ-031 Shared package i2c_master_pkg: Bit_cmd codes, state encodings.
REQ-032 One sub-module i2c_shift_reg (DW-wide, load/shift/serial in/out) is natural; counters and FSM in top.

Verification
REQ-033 Write burst Burst_len=3, Tx_data A5,3C,FF, slave ACKs -> 27 Bit_cmd WRITE/READ pairs in order, 3 Tx_req pulses, 1 I2C_done.
REQ-034 Start+Read Burst_len=2, slave sends 81,7E -> Rx_valid twice with 81 then 7E; macro defined: second ACK bit = 1 even with Tx_ack=0.
REQ-035 Write burst Burst_len=4, NACK after word 2 with Stop=1 -> Rx_ack=1, STOP issued, only 2 Tx_req, I2C_done.
REQ-036 I2C_al pulse mid-word 1 of 3 -> IDLE next cycle, Bit_cmd NOP, Al_err=1, I2C_done; next command clears Al_err.
REQ-037 Burst_len=0 write, DW=12 -> exactly one 12-bit word plus ACK; Rst_n low mid-word -> all outputs at reset values, no I2C_done.
